// File: rtl/debounce_bank.sv
// debounce_bank
//   Multi-channel debouncer for buttons and switches, placed between pad inputs
//   and UI logic. Each channel has the following stages:
//     - a 2-FF synchroniser
//     - a stability filter
//     - registered rise/fall pulses
//     - a long-press (hold) detector with auto-repeat
//   All channels share one 1 ms prescaler tick, so the counter widths do not
//   depend on CLK_HZ.
//
// Ports
//   clk    in   1         clock
//   rst    in   1         reset, asynchronous, active-high
//   in     in   CHANNELS  raw asynchronous inputs (inverted first when ACTIVE_LOW)
//   level  out  CHANNELS  debounced level, 1 = pressed / active
//   rise   out  CHANNELS  1-cycle pulse in the first cycle level shows 1
//   fall   out  CHANNELS  1-cycle pulse in the first cycle level shows 0
//   hold   out  CHANNELS  1-cycle pulse, once per press, after HOLD_MS pressed
//   rpt    out  CHANNELS  1-cycle auto-repeat pulse every REPEAT_MS after hold
//                         ('repeat' is a reserved word, hence the short name)
module debounce_bank #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int CHANNELS    = 4,
    parameter int DEBOUNCE_MS = 20,
    parameter int HOLD_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold,
    output logic [CHANNELS-1:0] rpt
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW       = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
    localparam int HMAX     = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int HW       = (HMAX > 1) ? $clog2(HMAX) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_MS - 1);
    localparam logic [HW-1:0] R_LAST = HW'(REPEAT_MS - 1);

    if ((CLK_HZ % 1000) != 0 || CLK_HZ < 2000) begin : g_bad_clk
        $error("debounce_bank: CLK_HZ must be a multiple of 1000 and at least 2000");
    end
    if (DEBOUNCE_MS == 0) begin : g_bad_debounce
        $error("debounce_bank: DEBOUNCE_MS must be at least 1");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("debounce_bank: CHANNELS must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_REPEAT
    } hstate_t;

    logic [CHANNELS-1:0] in_norm;
    logic [CHANNELS-1:0] sync1_d, sync1_q, sync2_d, sync2_q;
    logic [PW-1:0]       pcnt_d, pcnt_q;
    logic                tick;
    logic [CHANNELS-1:0] cand_d, cand_q;
    logic [DW-1:0]       dcnt_d [CHANNELS];
    logic [DW-1:0]       dcnt_q [CHANNELS];
    logic [CHANNELS-1:0] level_d, level_q;
    logic [CHANNELS-1:0] rise_d, rise_q, fall_d, fall_q;
    logic [CHANNELS-1:0] hold_d, hold_q, rpt_d, rpt_q;
    hstate_t             state_d [CHANNELS];
    hstate_t             state_q [CHANNELS];
    logic [HW-1:0]       hcnt_d [CHANNELS];
    logic [HW-1:0]       hcnt_q [CHANNELS];

    // Normalising before the synchroniser means an idle pad maps to 0, the
    // same value the sync flops reset to, so leaving reset creates no edge.
    assign in_norm = ACTIVE_LOW ? ~in : in;

    assign tick = (pcnt_q == P_LAST);

    always_comb begin
        sync1_d = in_norm;
        sync2_d = sync1_q;
        pcnt_d  = tick ? '0 : pcnt_q + PW'(1);
    end

    // Stability filter. Any disagreement between the synchronised input and the
    // candidate restarts the count, even in a tick cycle. A candidate that differs
    // from the accepted level is accepted on its DEBOUNCE_MS-th tick.
    always_comb begin
        cand_d  = cand_q;
        level_d = level_q;
        for (int i = 0; i < CHANNELS; i++) begin
            dcnt_d[i] = dcnt_q[i];
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync2_q[i] != cand_q[i]) begin
                cand_d[i] = sync2_q[i];
                dcnt_d[i] = '0;
            end else if (cand_q[i] != level_q[i]) begin
                if (tick) begin
                    if (dcnt_q[i] == D_LAST) begin
                        level_d[i] = cand_q[i];
                        dcnt_d[i]  = '0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DW'(1);
                    end
                end
            end else begin
                dcnt_d[i] = '0;
            end
        end
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    // Hold / auto-repeat per channel. The next level (level_d) is used rather
    // than the registered one, so a release that coincides with a hold or repeat
    // tick suppresses that pulse. Entry into PRESS happens on the accept edge
    // itself, so the accepting tick is never counted toward the hold time.
    // After hold the channel always parks in REPEAT; with REPEAT_MS == 0 it
    // just idles there, which keeps hold to a single pulse per press.
    always_comb begin
        hold_d = '0;
        rpt_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            hcnt_d[i]  = hcnt_q[i];
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (HOLD_MS == 0 || !level_d[i]) begin
                state_d[i] = ST_IDLE;
                hcnt_d[i]  = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        state_d[i] = ST_PRESS;
                        hcnt_d[i]  = '0;
                    end
                    ST_PRESS: begin
                        if (tick) begin
                            if (hcnt_q[i] == H_LAST) begin
                                hold_d[i]  = 1'b1;
                                hcnt_d[i]  = '0;
                                state_d[i] = ST_REPEAT;
                            end else begin
                                hcnt_d[i] = hcnt_q[i] + HW'(1);
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (REPEAT_MS != 0 && tick) begin
                            if (hcnt_q[i] == R_LAST) begin
                                rpt_d[i]  = 1'b1;
                                hcnt_d[i] = '0;
                            end else begin
                                hcnt_d[i] = hcnt_q[i] + HW'(1);
                            end
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        hcnt_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pcnt_q  <= '0;
            cand_q  <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            hold_q  <= '0;
            rpt_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                dcnt_q[i]  <= '0;
                state_q[i] <= ST_IDLE;
                hcnt_q[i]  <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            pcnt_q  <= pcnt_d;
            cand_q  <= cand_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            hold_q  <= hold_d;
            rpt_q   <= rpt_d;
            for (int i = 0; i < CHANNELS; i++) begin
                dcnt_q[i]  <= dcnt_d[i];
                state_q[i] <= state_d[i];
                hcnt_q[i]  <= hcnt_d[i];
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign hold  = hold_q;
    assign rpt   = rpt_q;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank
//   Directed bench for debounce_bank with T = 10 cycles per tick, 2 channels,
//   3-tick debounce, 10-tick hold and 4-tick repeat. A second instance with
//   ACTIVE_LOW = 1 shares the clock and reset and idles with its pads high.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_main, in_al;
    logic [1:0] level, rise, fall, hold, rpt;
    logic [1:0] al_level, al_rise, al_fall, al_hold, al_rpt;

    always #5 clk = ~clk;

    debounce_bank #(
        .CLK_HZ(10_000), .CHANNELS(2), .DEBOUNCE_MS(3),
        .HOLD_MS(10), .REPEAT_MS(4), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .in(in_main),
        .level(level), .rise(rise), .fall(fall), .hold(hold), .rpt(rpt)
    );

    debounce_bank #(
        .CLK_HZ(10_000), .CHANNELS(2), .DEBOUNCE_MS(3),
        .HOLD_MS(10), .REPEAT_MS(4), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst(rst), .in(in_al),
        .level(al_level), .rise(al_rise), .fall(al_fall), .hold(al_hold), .rpt(al_rpt)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_edge   = 0;

    // Channel-0 event bookkeeping for the main instance.
    int   n_rise0, n_fall0, n_hold0, n_rpt0, n_ch1;
    int   n_lvl0_chg, n_edge_bad, rpt_gap_bad, n_rpt_after_fall;
    int   t_rise0, t_hold0, t_last_hr;
    logic prev_level0;

    // Active-low instance bookkeeping; only cleared by the test that uses it.
    int n_al_rise1 = 0;
    int n_al_fall1 = 0;
    int n_al_other = 0;

    task automatic clearCounts();
        n_rise0 = 0; n_fall0 = 0; n_hold0 = 0; n_rpt0 = 0; n_ch1 = 0;
        n_lvl0_chg = 0; n_edge_bad = 0; rpt_gap_bad = 0; n_rpt_after_fall = 0;
        t_rise0 = 0; t_hold0 = 0; t_last_hr = 0;
        prev_level0 = level[0];
    endtask

    // Drive in_main and advance the given number of cycles, recording events.
    task automatic applyStimulus(input logic [1:0] value, input int cycles);
        logic exp_rise, exp_fall;
        in_main = value;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rise[0]) begin n_rise0++; t_rise0 = cyc; end
            if (fall[0]) n_fall0++;
            if (hold[0]) begin n_hold0++; t_hold0 = cyc; t_last_hr = cyc; end
            if (rpt[0]) begin
                n_rpt0++;
                if (cyc - t_last_hr != 40) rpt_gap_bad++;
                if (n_fall0 > 0) n_rpt_after_fall++;
                t_last_hr = cyc;
            end
            if (level[0] != prev_level0) n_lvl0_chg++;
            exp_rise = level[0] & ~prev_level0;
            exp_fall = ~level[0] & prev_level0;
            if (rise[0] !== exp_rise || fall[0] !== exp_fall) n_edge_bad++;
            prev_level0 = level[0];
            if (level[1] | rise[1] | fall[1] | hold[1] | rpt[1]) n_ch1++;
            if (al_rise[1]) n_al_rise1++;
            if (al_fall[1]) n_al_fall1++;
            if (al_level[0] | al_rise[0] | al_fall[0] | al_hold[0] | al_rpt[0] |
                al_hold[1] | al_rpt[1]) n_al_other++;
        end
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkWindow(input string tag, input int observed, input int lo, input int hi);
        checks++;
        assert ((observed >= lo) && (observed <= hi)) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
        end
    endtask

    initial begin
        rst     = 1'b1;
        in_main = 2'b00;
        in_al   = 2'b11;
        clearCounts();

        // Reset state.
        applyStimulus(2'b00, 3);
        checkOutput("reset_main_outputs", int'({level, rise, fall, hold, rpt}), 0);
        checkOutput("reset_al_outputs", int'({al_level, al_rise, al_fall, al_hold, al_rpt}), 0);
        rst = 1'b0;
        clearCounts();
        applyStimulus(2'b00, 30);
        checkOutput("post_reset_quiet", n_rise0 + n_fall0 + n_ch1, 0);

        // Test 1: clean press on channel 0.
        $display("[TB] test 1: clean press");
        clearCounts();
        t_edge = cyc;
        applyStimulus(2'b01, 40);
        checkOutput("t1_rise_count", n_rise0, 1);
        checkWindow("t1_rise_latency", t_rise0 - t_edge, 23, 33);
        checkOutput("t1_edge_pulses", n_edge_bad, 0);
        checkOutput("t1_level", int'(level[0]), 1);
        checkOutput("t1_ch1_quiet", n_ch1, 0);

        // Test 2: bounce every 15 cycles, then settle high.
        $display("[TB] test 2: bouncing input");
        applyStimulus(2'b00, 40);
        clearCounts();
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k % 2 == 0) ? 2'b01 : 2'b00, 15);
        end
        checkOutput("t2_no_rise_while_bouncing", n_rise0, 0);
        checkOutput("t2_level_low_while_bouncing", int'(level[0]), 0);
        t_edge = cyc;
        applyStimulus(2'b01, 40);
        checkOutput("t2_rise_count", n_rise0, 1);
        checkWindow("t2_rise_latency", t_rise0 - t_edge, 23, 33);
        checkOutput("t2_edge_pulses", n_edge_bad, 0);

        // Test 3: keep holding (300 cycles after the edge), then release.
        $display("[TB] test 3: hold and repeat");
        applyStimulus(2'b01, 260);
        checkOutput("t3_hold_count", n_hold0, 1);
        checkWindow("t3_hold_latency", t_hold0 - t_rise0, 91, 100);
        checkOutput("t3_repeat_count", n_rpt0, 4);
        checkOutput("t3_repeat_spacing", rpt_gap_bad, 0);
        applyStimulus(2'b00, 60);
        checkOutput("t3_fall_count", n_fall0, 1);
        checkOutput("t3_no_repeat_after_fall", n_rpt_after_fall, 0);
        checkOutput("t3_level_released", int'(level[0]), 0);

        // Test 4: glitches while pressed. The glitch starts are placed a whole
        // number of ticks after the rise so the 25-cycle dropout cannot span
        // three full ticks.
        $display("[TB] test 4: glitches while pressed");
        clearCounts();
        applyStimulus(2'b01, 40);
        applyStimulus(2'b01, t_rise0 + 50 - cyc);
        applyStimulus(2'b00, 1);
        applyStimulus(2'b01, 9);
        applyStimulus(2'b00, 25);
        applyStimulus(2'b01, t_rise0 + 190 - cyc);
        checkOutput("t4_rise_count", n_rise0, 1);
        checkOutput("t4_no_fall", n_fall0, 0);
        checkOutput("t4_single_level_change", n_lvl0_chg, 1);
        checkOutput("t4_hold_count", n_hold0, 1);
        checkWindow("t4_hold_latency", t_hold0 - t_rise0, 91, 100);
        checkOutput("t4_repeat_count", n_rpt0, 2);
        checkOutput("t4_repeat_spacing", rpt_gap_bad, 0);

        // Test 5: reset in the middle of REPEAT with the button still held.
        $display("[TB] test 5: reset while repeating");
        rst = 1'b1;
        #1;
        checkOutput("t5_async_clear", int'({level, rise, fall, hold, rpt}), 0);
        applyStimulus(2'b01, 3);
        rst = 1'b0;
        clearCounts();
        t_edge = cyc;
        applyStimulus(2'b01, 23);
        checkOutput("t5_no_early_rise", n_rise0, 0);
        applyStimulus(2'b01, 27);
        checkOutput("t5_rise_count", n_rise0, 1);
        checkWindow("t5_rise_latency", t_rise0 - t_edge, 23, 33);
        applyStimulus(2'b01, 100);
        checkOutput("t5_hold_count", n_hold0, 1);
        checkWindow("t5_hold_latency", t_hold0 - t_rise0, 91, 100);
        checkOutput("t5_ch1_quiet", n_ch1, 0);

        // Test 6: active-low instance.
        $display("[TB] test 6: active-low channel");
        checkOutput("t6_idle_no_pulses", n_al_rise1 + n_al_fall1 + n_al_other, 0);
        in_al = 2'b01;
        applyStimulus(in_main, 40);
        checkOutput("t6_rise1_count", n_al_rise1, 1);
        checkOutput("t6_level_pressed", int'(al_level), 2);
        in_al = 2'b11;
        applyStimulus(in_main, 40);
        checkOutput("t6_fall1_count", n_al_fall1, 1);
        checkOutput("t6_level_released", int'(al_level), 0);
        checkOutput("t6_other_quiet", n_al_other, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
